// File: rtl/seg_scan_decoder.sv
// Recovers a 32-bit hex value from a multiplexed 7-segment display scan.
// Each digit must hold steady for STABLE_CYCLES sampled cycles before it is accepted.
//
// state   | meaning
// --------+---------------------------------------------------------------
// WAIT    | no digit selected (blank or multi-select scan pattern)
// COUNT   | a digit/segment pair is being qualified for stability
// HELD    | the current pair was accepted; waiting for the scan to move on
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [7:0]  ans,
    output logic [31:0] value,
    output logic        valid,
    output logic        bad_seg,
    output logic [7:0]  seen
);
    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;
    localparam logic [7:0] CNT_TC   = 8'(STABLE_CYCLES);

    logic [6:0]  s_seg, ref_seg;
    logic [7:0]  s_ans, ref_ans, sel;
    logic [1:0]  state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [31:0] shadow, shadow_n;
    logic        onehot, same, load_ref, accept, is_hex;
    logic [3:0]  nib;

    // Returns {recognised, nibble}; patterns are active-low {g..a}.
    function automatic logic [4:0] hex_dec(input logic [6:0] p);
        case (p)
            7'h40: hex_dec = 5'h10;
            7'h79: hex_dec = 5'h11;
            7'h24: hex_dec = 5'h12;
            7'h30: hex_dec = 5'h13;
            7'h19: hex_dec = 5'h14;
            7'h12: hex_dec = 5'h15;
            7'h02: hex_dec = 5'h16;
            7'h78: hex_dec = 5'h17;
            7'h00: hex_dec = 5'h18;
            7'h10: hex_dec = 5'h19;
            7'h08: hex_dec = 5'h1A;
            7'h03: hex_dec = 5'h1B;
            7'h46: hex_dec = 5'h1C;
            7'h21: hex_dec = 5'h1D;
            7'h06: hex_dec = 5'h1E;
            7'h0E: hex_dec = 5'h1F;
            default: hex_dec = 5'h00;
        endcase
    endfunction

    assign sel    = ~s_ans;
    assign onehot = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
    assign same   = (s_seg == ref_seg) && (s_ans == ref_ans);
    assign {is_hex, nib} = hex_dec(s_seg);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        load_ref = 1'b0;
        accept   = 1'b0;
        case (state)
            ST_WAIT: begin
                if (onehot) begin
                    state_n  = ST_COUNT;
                    cnt_n    = 8'd1;
                    load_ref = 1'b1;
                end
            end
            ST_COUNT: begin
                if (!onehot) begin
                    state_n = ST_WAIT;
                end else if (!same) begin
                    cnt_n    = 8'd1;
                    load_ref = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ST_HELD: begin
                if (!onehot) begin
                    state_n = ST_WAIT;
                end else if (!same) begin
                    state_n  = ST_COUNT;
                    cnt_n    = 8'd1;
                    load_ref = 1'b1;
                end
            end
            default: state_n = ST_WAIT;
        endcase
        // Accept on the cycle the count reaches the threshold, so a pair
        // held for exactly STABLE_CYCLES samples is taken.
        if (state_n == ST_COUNT && cnt_n == CNT_TC) begin
            accept  = 1'b1;
            state_n = ST_HELD;
        end
    end

    always_comb begin
        shadow_n = shadow;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) shadow_n[4*i +: 4] = nib;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_seg   <= 7'h7F;
            s_ans   <= 8'hFF;
            ref_seg <= 7'h7F;
            ref_ans <= 8'hFF;
            state   <= ST_WAIT;
            cnt     <= 8'd0;
            shadow  <= 32'h0;
            value   <= 32'h0;
            valid   <= 1'b0;
            bad_seg <= 1'b0;
            seen    <= 8'h00;
        end else begin
            s_seg   <= seg;
            s_ans   <= ans;
            state   <= state_n;
            cnt     <= cnt_n;
            valid   <= 1'b0;
            bad_seg <= 1'b0;
            if (load_ref) begin
                ref_seg <= s_seg;
                ref_ans <= s_ans;
            end
            if (accept) begin
                if (is_hex) begin
                    shadow <= shadow_n;
                    if ((seen | sel) == 8'hFF) begin
                        value <= shadow_n;
                        valid <= 1'b1;
                        seen  <= 8'h00;
                    end else begin
                        seen <= seen | sel;
                    end
                end else begin
                    bad_seg <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a run-length reference model predicts
// accepted digits, completed frames and bad-segment events from the pin sequence.
module tb_seg_scan_decoder;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [7:0]  ans = 8'hFF;
    logic [31:0] value;
    logic        valid, bad_seg;
    logic [7:0]  seen;

    seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .seg(seg), .ans(ans),
        .value(value), .valid(valid), .bad_seg(bad_seg), .seen(seen)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_chk = 0, n_fail = 0, n_valid = 0, exp_bad = 0;
    logic [31:0] frame_q [$];
    logic [31:0] last_frame = 32'h0;

    // reference model state
    logic [3:0] m_nib [8];
    logic [7:0] m_seen = 8'h00;
    logic [6:0] p_seg = 7'h7F;
    logic [7:0] p_ans = 8'hFF;
    int run_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hex_of(input logic [6:0] p);
        for (int k = 0; k < 16; k++) if (hex_tab[k] == p) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_seen = 8'h00;
        for (int k = 0; k < 8; k++) m_nib[k] = 4'h0;
        p_seg = 7'h7F;
        p_ans = 8'hFF;
        run_len = 0;
    endtask

    // A one-hot-low pair is accepted once, when its unbroken run reaches S samples.
    task automatic model_cycle(input logic [6:0] s, input logic [7:0] a);
        int d, h;
        logic [31:0] f;
        if (s == p_seg && a == p_ans) run_len++;
        else run_len = 1;
        p_seg = s;
        p_ans = a;
        if ($countones(~a) == 1 && run_len == S) begin
            d = 0;
            for (int k = 0; k < 8; k++) if (!a[k]) d = k;
            h = hex_of(s);
            if (h < 0) begin
                exp_bad++;
            end else begin
                m_nib[d] = h[3:0];
                m_seen[d] = 1'b1;
                if (m_seen == 8'hFF) begin
                    f = 32'h0;
                    for (int k = 0; k < 8; k++) f = f | (32'(m_nib[k]) << (4 * k));
                    frame_q.push_back(f);
                    m_seen = 8'h00;
                end
            end
        end
    endtask

    task automatic cyc(input logic [6:0] s, input logic [7:0] a);
        seg = s;
        ans = a;
        model_cycle(s, a);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] s, input logic [7:0] a, input int n);
        for (int k = 0; k < n; k++) cyc(s, a);
    endtask

    task automatic put_digit(input logic [31:0] v, input int d, input int n);
        logic [7:0] a;
        a = ~(8'h01 << d);
        hold(hex_tab[v[4*d +: 4]], a, n);
    endtask

    task automatic scan(input logic [31:0] v, input int n);
        for (int d = 0; d < 8; d++) put_digit(v, d, n);
    endtask

    task automatic drain();
        hold(7'h7F, 8'hFF, S + 4);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        seg = 7'h7F;
        ans = 8'hFF;
        model_reset();
        last_frame = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_value", value, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_bad", {31'h0, bad_seg}, 32'h0);
        chk("rst_seen", {24'h0, seen}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("valid_bad_excl", {31'h0, valid & bad_seg}, 32'h0);
            if (valid) begin
                n_valid++;
                chk("valid_expected", {31'h0, frame_q.size() != 0}, 32'h1);
                if (frame_q.size() != 0) begin
                    last_frame = frame_q.pop_front();
                    chk("frame_value", value, last_frame);
                end
            end else begin
                chk("value_hold", value, last_frame);
            end
            if (bad_seg) begin
                chk("bad_expected", {31'h0, exp_bad > 0}, 32'h1);
                if (exp_bad > 0) exp_bad--;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, r, len, d;
        logic [6:0] s;
        logic [7:0] a;
        logic [31:0] rv;

        for (int k = 0; k < 8; k++) m_nib[k] = 4'h0;
        @(posedge clk);
        #1;
        do_reset();

        // full scan, 6 cycles per digit
        v0 = n_valid;
        scan(32'h12345678, 6);
        drain();
        chk("scan1_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("scan1_value", value, 32'h12345678);
        chk("scan1_seen", {24'h0, seen}, 32'h0);

        // digit 3 held too briefly, then completed later
        v0 = n_valid;
        for (int k = 0; k < 8; k++) put_digit(32'h9ABCDEF0, k, (k == 3) ? 3 : 6);
        drain();
        chk("short_no_valid", 32'(n_valid - v0), 32'd0);
        chk("short_seen", {24'h0, seen}, 32'hF7);
        chk("short_seen_model", {24'h0, seen}, {24'h0, m_seen});
        put_digit(32'h9ABCDEF0, 3, 4);
        drain();
        chk("short_done_valid", 32'(n_valid - v0), 32'd1);
        chk("short_done_value", value, 32'h9ABCDEF0);

        // non-hex segment pattern on digit 2
        put_digit(32'h00000011, 0, 5);
        hold(7'h7F, 8'hFB, 5);
        drain();
        chk("bad_seen2", {31'h0, seen[2]}, 32'h0);
        chk("bad_seen", {24'h0, seen}, 32'h01);
        chk("bad_consumed", 32'(exp_bad), 32'h0);

        // multi-select and blank patterns accept nothing
        hold(hex_tab[5], 8'hFC, 8);
        hold(hex_tab[6], 8'hFF, 8);
        hold(hex_tab[7], 8'h00, 8);
        drain();
        chk("idle_seen", {24'h0, seen}, 32'h01);

        // reset mid-frame discards partial digits
        for (int k = 0; k < 5; k++) put_digit(32'h55555555, k, 6);
        drain();
        chk("pre_rst_seen", {24'h0, seen}, 32'h1F);
        do_reset();
        v0 = n_valid;
        scan(32'hDEADBEEF, 6);
        drain();
        chk("dead_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("dead_value", value, 32'hDEADBEEF);

        // continuous repeated scan, no gaps
        v0 = n_valid;
        for (int k = 0; k < 3; k++) scan(32'hCAFE0001, 5);
        drain();
        chk("cafe_valid_cnt", 32'(n_valid - v0), 32'd3);
        chk("cafe_value", value, 32'hCAFE0001);
        chk("cafe_no_bad", 32'(exp_bad), 32'h0);

        // random scans and random pin noise
        for (int k = 0; k < 4; k++) begin
            rv = $urandom;
            scan(rv, $urandom_range(S, S + 3));
        end
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            len = $urandom_range(1, 6);
            d = $urandom_range(0, 7);
            if (r < 6) begin
                a = ~(8'h01 << d);
                s = ($urandom_range(0, 5) == 0) ? 7'($urandom) : hex_tab[$urandom_range(0, 15)];
            end else if (r < 8) begin
                a = 8'hFF;
                s = 7'($urandom);
            end else begin
                a = 8'($urandom);
                s = hex_tab[$urandom_range(0, 15)];
            end
            hold(s, a, len);
        end
        drain();
        chk("rand_seen", {24'h0, seen}, {24'h0, m_seen});
        chk("frames_drained", 32'(frame_q.size()), 32'h0);
        chk("bad_drained", 32'(exp_bad), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
